// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, issues icache requests and fills the IF/ID latch bundle.
// Optional IFETCH_PERF_EN adds saturating fetch/stall event counters as extra outputs.
module ifetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        fd_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pcplusfour_out
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  // state      | meaning
  // FETCH      | normal fetch; hits fill the latch bundle
  // REDIR_PEND | redirect arrived during a miss; wait for the miss, then jump to pend_pc
  // HALTED     | fetch stopped until reset
  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] instr_n, pc_out_n, pc4_n;
  logic        valid_n;
  logic        accept;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;
  assign imemaddr = pc;
  assign imemREN  = (state != HALTED);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    instr_n   = instr_out;
    pc_out_n  = pc_out;
    pc4_n     = pcplusfour_out;
    valid_n   = fd_valid;
    accept    = 1'b0;

    case (state)
      FETCH: begin
        if (halt && !redirect_en) begin
          state_n = HALTED;
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
        end else if (redirect_en) begin
          // a redirect flushes younger stages, so it wins over stall
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
          if (ihit) begin
            pc_n = redirect_pc;
          end else begin
            pend_pc_n = redirect_pc;
            state_n   = REDIR_PEND;
          end
        end else if (stall) begin
          state_n = FETCH;
        end else if (ihit) begin
          accept   = 1'b1;
          instr_n  = imemload;
          pc_out_n = pc;
          pc4_n    = pc_plus4;
          valid_n  = 1'b1;
          pc_n     = pc_plus4;
        end else begin
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
        end
      end

      REDIR_PEND: begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
        if (halt && !redirect_en) begin
          state_n = HALTED;
        end else if (redirect_en) begin
          if (ihit) begin
            pc_n    = redirect_pc;
            state_n = FETCH;
          end else begin
            pend_pc_n = redirect_pc;
          end
        end else if (ihit) begin
          // the returning word belongs to the abandoned path
          pc_n    = pend_pc;
          state_n = FETCH;
        end
      end

      HALTED: begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
      end

      default: begin
        state_n = FETCH;
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state          <= FETCH;
      pc             <= PC_RESET;
      pend_pc        <= 32'h0;
      instr_out      <= NOP_INSTR;
      pc_out         <= 32'h0;
      pcplusfour_out <= 32'h0;
      fd_valid       <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      pend_pc        <= pend_pc_n;
      instr_out      <= instr_n;
      pc_out         <= pc_out_n;
      pcplusfour_out <= pc4_n;
      fd_valid       <= valid_n;
    end
  end

`ifdef IFETCH_PERF_EN
  logic stall_event;

  assign stall_event = imemREN && (stall || !ihit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (accept && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (stall_event && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage; accepted fetches are queued as expected latch bundles.
// Counter checks are compiled in when IFETCH_PERF_EN is defined.
module tb_ifetch_stage;

  localparam logic [31:0] PC_RESET  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        fd_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcplusfour_out;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;

  always #5 CLK = ~CLK;

  ifetch_stage #(.PC_RESET(PC_RESET), .NOP_INSTR(NOP_INSTR)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .ihit(ihit),
    .imemload(imemload),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .fd_valid(fd_valid),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .pcplusfour_out(pcplusfour_out)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Inputs must already be driven; accept says whether this edge should latch a bundle.
  task automatic fetch_cycle(input string tag, input logic accept);
    exp_t e;
    if (accept) begin
      e.instr = imemload;
      e.pc    = mpc;
      e.pc4   = mpc + 32'd4;
      sb_q.push_back(e);
    end
    tick();
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, 32'(fd_valid), 32'd1);
      check({tag, "_instr"}, instr_out, e.instr);
      check({tag, "_pc"}, pc_out, e.pc);
      check({tag, "_pc4"}, pcplusfour_out, e.pc4);
    end else begin
      check({tag, "_bubble_valid"}, 32'(fd_valid), 32'd0);
      check({tag, "_bubble_instr"}, instr_out, NOP_INSTR);
    end
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = 32'h0; stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    mpc = PC_RESET;
    tick();
    tick();
    check("rst_addr", imemaddr, PC_RESET);
    check("rst_ren", 32'(imemREN), 32'd1);
    check("rst_valid", 32'(fd_valid), 32'd0);
    check("rst_instr", instr_out, NOP_INSTR);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc4", pcplusfour_out, 32'h0);
`ifdef IFETCH_PERF_EN
    check("rst_fetch_cnt", fetch_count, 32'h0);
    check("rst_stall_cnt", stall_count, 32'h0);
`endif
    nRST = 1'b1;

    // straight-line hits
    ihit = 1'b1;
    imemload = 32'h2001_0005;
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imemaddr, mpc);
      fetch_cycle("seq", 1'b1);
      mpc = mpc + 32'd4;
    end

    // stall freezes pc and bundle even though ihit is high
    stall = 1'b1;
    imemload = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imemaddr, 32'h10);
      check("stall_valid", 32'(fd_valid), 32'd1);
      check("stall_pc", pc_out, 32'h0C);
      check("stall_instr", instr_out, 32'h2001_0005);
    end
    stall = 1'b0;
    imemload = 32'h1111_0010;
    fetch_cycle("post_stall", 1'b1);
    mpc = mpc + 32'd4;

    // miss: bubble, pc_out keeps last value
    ihit = 1'b0;
    fetch_cycle("miss", 1'b0);
    check("miss_pc_hold", pc_out, 32'h10);
    check("miss_addr", imemaddr, 32'h14);

    ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imemload = 32'h3000_0000 | mpc;
      fetch_cycle("fill", 1'b1);
      mpc = mpc + 32'd4;
    end

    // redirect on a hit, with stall also asserted
    check("pre_redir_addr", imemaddr, 32'h20);
    redirect_en = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
    imemload = 32'hBAD0_0020;
    fetch_cycle("redir_hit", 1'b0);
    redirect_en = 1'b0; stall = 1'b0;
    mpc = 32'h100;
    check("redir_addr", imemaddr, 32'h100);
    imemload = 32'h4000_0100;
    fetch_cycle("redir_target", 1'b1);
    mpc = mpc + 32'd4;

    redirect_en = 1'b1; redirect_pc = 32'h30;
    fetch_cycle("redir_to30", 1'b0);
    redirect_en = 1'b0;
    mpc = 32'h30;

    // redirects during a miss: latest one wins once the miss resolves
    ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h200;
    fetch_cycle("pend1", 1'b0);
    check("pend1_addr", imemaddr, 32'h30);
    redirect_pc = 32'h300;
    fetch_cycle("pend2", 1'b0);
    check("pend2_addr", imemaddr, 32'h30);
    redirect_en = 1'b0;
    fetch_cycle("pend_wait", 1'b0);
    check("pend_wait_addr", imemaddr, 32'h30);
    ihit = 1'b1; imemload = 32'hBAD0_0030;
    fetch_cycle("pend_resolve", 1'b0);
    mpc = 32'h300;
    check("pend_resolve_addr", imemaddr, 32'h300);
    imemload = 32'h5000_0300;
    fetch_cycle("pend_target", 1'b1);
    mpc = mpc + 32'd4;

    // redirect and hit together while pending
    ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h400;
    fetch_cycle("pend3", 1'b0);
    ihit = 1'b1; redirect_pc = 32'h500;
    fetch_cycle("pend3_hit_redir", 1'b0);
    redirect_en = 1'b0;
    mpc = 32'h500;
    check("pend3_addr", imemaddr, 32'h500);

    // pc wraps at the top of the address space
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    fetch_cycle("redir_top", 1'b0);
    redirect_en = 1'b0;
    mpc = 32'hFFFF_FFFC;
    imemload = 32'h6000_FFFC;
    fetch_cycle("wrap", 1'b1);
    mpc = mpc + 32'd4;
    check("wrap_addr", imemaddr, 32'h0);

    // halt with redirect in the same cycle: redirect taken, halt ignored
    halt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
    fetch_cycle("halt_redir", 1'b0);
    check("halt_redir_ren", 32'(imemREN), 32'd1);
    check("halt_redir_addr", imemaddr, 32'h40);
    redirect_en = 1'b0;
    mpc = 32'h40;

    fetch_cycle("halt", 1'b0);
    check("halt_ren", 32'(imemREN), 32'd0);
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fetch_cycle("halted", 1'b0);
      check("halted_ren", 32'(imemREN), 32'd0);
      check("halted_addr", imemaddr, 32'h40);
    end

    nRST = 1'b0;
    tick();
    check("halt_rst_addr", imemaddr, PC_RESET);
    check("halt_rst_ren", 32'(imemREN), 32'd1);
    check("halt_rst_pc", pc_out, 32'h0);
    check("halt_rst_pc4", pcplusfour_out, 32'h0);
    nRST = 1'b1;
    mpc = PC_RESET;

    // reset while a redirect is pending discards it
    ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h700;
    fetch_cycle("rst_pend", 1'b0);
    redirect_en = 1'b0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    ihit = 1'b1; imemload = 32'h7000_0000;
    check("rst_pend_addr", imemaddr, PC_RESET);
    fetch_cycle("rst_pend_fetch", 1'b1);
    mpc = mpc + 32'd4;

    // counter window: 5 hits then 2 miss cycles from a fresh reset
    nRST = 1'b0; ihit = 1'b0;
    tick();
    nRST = 1'b1;
    mpc = PC_RESET;
    ihit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imemload = 32'h8000_0000 + 32'(i);
      fetch_cycle("perf_hit", 1'b1);
      mpc = mpc + 32'd4;
    end
    ihit = 1'b0;
    for (int i = 0; i < 2; i++) fetch_cycle("perf_miss", 1'b0);
    check("perf_addr", imemaddr, 32'h14);
`ifdef IFETCH_PERF_EN
    check("fetch_count", fetch_count, 32'd5);
    check("stall_count", stall_count, 32'd2);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
